data_memory_mp: RTL and testbench
=================================

# data_memory_mp

Parametrised multi-port data memory for the pipeline's memory stage. It generalises the fixed 8-bit, 4-read/4-write data memory to configurable width, depth and port counts, with an optional registered read path. Clearing is no longer a single-cycle operation: the block walks the array one word per cycle under a busy flag. Write collisions and out-of-range addresses are defined and reported.

## Interface
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 8, bits per address
- DEPTH, 256, number of words; must satisfy 2 <= DEPTH <= 2^ADDR_WIDTH
- NUM_RD, 4, read ports (>= 1)
- NUM_WR, 4, write ports (>= 1)
- RD_REGISTERED, 0, 0 = combinational read, 1 = one-cycle registered read

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  request full-array clear; sampled only in RUN
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing
- wr_addr  in  NUM_WR*ADDR_WIDTH  packed write addresses
- wr_data  in  NUM_WR*DATA_WIDTH  packed write data
- wr_enable  in  NUM_WR  per-port write strobe
- busy  out  1  high while clearing; reset value 1
- addr_error  out  1  one-cycle pulse: an enabled write targeted an address >= DEPTH; reset value 0

## Operation
- Two-state FSM: CLEAR, RUN. A clear counter spans 0..DEPTH-1.
- reset high at an edge: state <= CLEAR, counter <= 0, busy <= 1, addr_error <= 0, registered rd_data <= 0. Reset does not itself zero any array word.
- CLEAR, reset low: each edge writes 0 to mem[counter] and increments the counter. The edge that writes DEPTH-1 sets state <= RUN and busy <= 0.
- In CLEAR, all wr_enable are ignored, and rd_data is forced to 0 on every port in both read modes. addr_error stays 0.
- RUN: each edge commits every enabled, in-range write. If clear is high, state <= CLEAR, counter <= 0 and busy <= 1 on that edge; writes on that same edge still commit and are then overwritten by the walk.
- Collision: when several enabled ports share an address, the highest-index port wins.
- Out of range (addr >= DEPTH):
  - the write is dropped, and addr_error is 1 for the cycle after the edge;
  - a read returns 0.
- Read, RD_REGISTERED=0: rd_data[i] = mem[rd_addr[i]], combinational. There is no write bypass, so a written value is visible after the commit edge.
- Read, RD_REGISTERED=1: rd_data[i] is registered from mem[rd_addr[i]] at the edge, with read-before-write semantics. A read and a write to the same address on one edge return the old value.
- No arithmetic other than the counter. The counter width is ADDR_WIDTH+1 so DEPTH = 2^ADDR_WIDTH terminates correctly.

## Timing
- Clear duration: exactly DEPTH edges with reset low. busy falls after the DEPTH-th such edge.
- Reset asserted mid-clear: the counter restarts at 0 and the full DEPTH edges are required again.
- Reset asserted in RUN: same as power-up; contents persist until walked.
- Write-to-read latency: 1 edge for the combinational read. The registered read presents data one edge after the address is sampled.
- addr_error: registered, high for exactly one cycle per offending edge. It is not sticky.
- clear held high continuously: a new clear starts on the first RUN edge after each walk completes.

## Test plan
- Reset for 1 edge, DEPTH=256, then release: busy=1 for 256 edges, then 0. All reads return 0, including after prior contents 0xAA.
- RUN, writes: port0 writes 0x11 to addr 5, port3 writes 0x33 to addr 5, port1 writes 0x22 to addr 6 on the same edge. Next cycle: read addr 5 = 0x33, read addr 6 = 0x22.
- DEPTH=200, ADDR_WIDTH=8: write to addr 210 → addr_error pulses for 1 cycle and no array word changes. Read of addr 210 = 0.
- RD_REGISTERED=1: mem[7]=0x40, then on one edge write 0x41 and read addr 7. rd_data = 0x40 after that edge and 0x41 after the next.
- Reset asserted at clear step 100, held 1 edge: busy stays 1 for a further 256 edges. wr_enable pulses during the walk leave no trace.
- clear pulsed in RUN alongside a write of 0x55 to addr 3: busy rises, and after the walk mem[3]=0.

Source files
------------

// File: rtl/data_memory_mp.sv
// Parametrised multi-port data memory: sequential one-word-per-cycle clear walk,
// highest-index write port wins on collision, out-of-range writes dropped and flagged.
module data_memory_mp #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned NUM_RD        = 4,
   parameter int unsigned NUM_WR        = 4,
   parameter int unsigned RD_REGISTERED = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           clear,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
   input  logic [NUM_WR-1:0]              wr_enable,
   output logic                           busy,
   output logic                           addr_error
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                        state;
   logic [CNT_W-1:0]              clr_cnt;
   logic [DATA_WIDTH-1:0]         mem [DEPTH];
   logic [NUM_WR-1:0]             wr_ok;
   logic [NUM_WR-1:0]             wr_bad;
   logic [NUM_RD*DATA_WIDTH-1:0]  rd_word;

   // Range checks are done one bit wider so DEPTH = 2^ADDR_WIDTH never overflows.
   always_comb begin
      wr_ok  = '0;
      wr_bad = '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         if ({1'b0, wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_W)
            wr_ok[i] = wr_enable[i];
         else
            wr_bad[i] = wr_enable[i];
      end
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if ({1'b0, rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_W)
            rd_word[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[i*ADDR_WIDTH +: IDX_W]];
      end
   end

   // Ascending port order: the last non-blocking write, i.e. the highest port, wins.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clr_cnt[IDX_W-1:0]] <= '0;
         end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
               if (wr_ok[i])
                  mem[wr_addr[i*ADDR_WIDTH +: IDX_W]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         busy       <= 1'b1;
         addr_error <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               addr_error <= 1'b0;
               if (clr_cnt == LAST) begin
                  state   <= RUN;
                  busy    <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               addr_error <= |wr_bad;
               if (clear) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   if (RD_REGISTERED != 0) begin : g_rd_reg
      logic [NUM_RD*DATA_WIDTH-1:0] rd_q;

      always_ff @(posedge clock) begin
         if (reset || state == CLEAR)
            rd_q <= '0;
         else
            rd_q <= rd_word;
      end

      assign rd_data = (state == RUN) ? rd_q : '0;
   end else begin : g_rd_comb
      assign rd_data = (state == RUN) ? rd_word : '0;
   end

endmodule

// File: tb/tb_data_memory_mp.sv
// Directed bench: instance a is 256-deep combinational read, instance b is
// 200-deep registered read; both share clock and reset.
module tb_data_memory_mp;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        a_clear = 1'b0;
   logic [31:0] a_rd_addr = '0;
   logic [31:0] a_rd_data;
   logic [31:0] a_wr_addr = '0;
   logic [31:0] a_wr_data = '0;
   logic [3:0]  a_wr_en = '0;
   logic        a_busy;
   logic        a_err;

   logic        b_clear = 1'b0;
   logic [31:0] b_rd_addr = '0;
   logic [31:0] b_rd_data;
   logic [31:0] b_wr_addr = '0;
   logic [31:0] b_wr_data = '0;
   logic [3:0]  b_wr_en = '0;
   logic        b_busy;
   logic        b_err;

   int checks = 0;
   int errors = 0;

   data_memory_mp #(
      .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256),
      .NUM_RD(4), .NUM_WR(4), .RD_REGISTERED(0)
   ) u_a (
      .clock(clock), .reset(reset), .clear(a_clear),
      .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_enable(a_wr_en),
      .busy(a_busy), .addr_error(a_err)
   );

   data_memory_mp #(
      .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200),
      .NUM_RD(4), .NUM_WR(4), .RD_REGISTERED(1)
   ) u_b (
      .clock(clock), .reset(reset), .clear(b_clear),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_enable(b_wr_en),
      .busy(b_busy), .addr_error(b_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic walk_a(output int n);
      n = 0;
      while (a_busy && n < 1000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int na;
      int nb;

      // reset state
      tick();
      chk("a_busy_rst", {31'b0, a_busy}, 32'd1);
      chk("a_err_rst", {31'b0, a_err}, 32'd0);
      chk("b_busy_rst", {31'b0, b_busy}, 32'd1);
      chk("b_rd_rst", b_rd_data, 32'd0);
      reset = 1'b0;

      // power-up walk lengths: DEPTH edges each
      na = 0;
      nb = 0;
      for (int n = 1; n <= 1000; n++) begin
         tick();
         if (!a_busy && na == 0) na = n;
         if (!b_busy && nb == 0) nb = n;
         if (na != 0 && nb != 0) break;
      end
      chk("a_walk_len", na, 32'd256);
      chk("b_walk_len", nb, 32'd200);

      // fill 0..3 with 0xAA, then reset and confirm the walk zeroes them
      a_wr_addr = {8'd3, 8'd2, 8'd1, 8'd0};
      a_wr_data = 32'hAAAA_AAAA;
      a_wr_en   = 4'hF;
      a_rd_addr = {8'd3, 8'd2, 8'd1, 8'd0};
      tick();
      a_wr_en = '0;
      chk("a_wr4", a_rd_data, 32'hAAAA_AAAA);
      chk("a_err_inrange", {31'b0, a_err}, 32'd0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("a_busy_rerst", {31'b0, a_busy}, 32'd1);
      tick();
      chk("a_rd_forced0", a_rd_data, 32'd0);
      walk_a(na);
      chk("a_walk_rest", na, 32'd255);
      chk("a_cleared", a_rd_data, 32'd0);

      // collision: port3 beats port0 at addr 5; no write bypass
      a_wr_addr = {8'd5, 8'd0, 8'd6, 8'd5};
      a_wr_data = {8'h33, 8'h00, 8'h22, 8'h11};
      a_wr_en   = 4'b1011;
      a_rd_addr = {8'd0, 8'd0, 8'd6, 8'd5};
      #1;
      chk("a_no_bypass", a_rd_data, 32'd0);
      tick();
      a_wr_en = '0;
      chk("a_collision", a_rd_data[15:0], 16'h2233);

      // reset at clear step 100 with writes attempted throughout the walk
      a_wr_addr = {8'd0, 8'd0, 8'd255, 8'd10};
      a_wr_data = {8'h00, 8'h00, 8'h78, 8'h77};
      a_rd_addr = {8'd0, 8'd0, 8'd255, 8'd10};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int n = 0; n < 100; n++) begin
         a_wr_en = (n % 2 == 0) ? 4'b0011 : 4'b0000;
         tick();
      end
      chk("a_busy_step100", {31'b0, a_busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_wr_en = 4'b0011;
      walk_a(na);
      a_wr_en = '0;
      chk("a_walk_midrst", na, 32'd256);
      chk("a_wr_ignored", a_rd_data[15:0], 16'h0000);

      // clear in RUN alongside a write of 0x55 to addr 3
      a_wr_addr = {8'd0, 8'd0, 8'd0, 8'd3};
      a_wr_data = {24'h0, 8'h55};
      a_wr_en   = 4'b0001;
      a_rd_addr = {8'd0, 8'd0, 8'd0, 8'd3};
      a_clear   = 1'b1;
      tick();
      a_clear = 1'b0;
      a_wr_en = '0;
      chk("a_clear_busy", {31'b0, a_busy}, 32'd1);
      walk_a(na);
      chk("a_clear_len", na, 32'd256);
      chk("a_clear_mem3", a_rd_data[7:0], 8'h00);

      // clear held high: a new walk starts on the first RUN edge
      a_clear = 1'b1;
      tick();
      walk_a(na);
      chk("a_held_len", na, 32'd256);
      chk("a_held_idle", {31'b0, a_busy}, 32'd0);
      tick();
      chk("a_held_restart", {31'b0, a_busy}, 32'd1);
      a_clear = 1'b0;
      walk_a(na);
      chk("a_held_len2", na, 32'd256);

      // out-of-range write on the 200-deep instance
      b_wr_addr = {8'd0, 8'd0, 8'd0, 8'd210};
      b_wr_data = {24'h0, 8'hEE};
      b_wr_en   = 4'b0001;
      b_rd_addr = {8'd199, 8'd82, 8'd10, 8'd210};
      tick();
      b_wr_en = '0;
      chk("b_err_pulse", {31'b0, b_err}, 32'd1);
      tick();
      chk("b_err_drop", {31'b0, b_err}, 32'd0);
      chk("b_oor_rd", b_rd_data, 32'd0);

      // last valid address: no error, visible after registered latency
      b_wr_addr = {8'd0, 8'd0, 8'd0, 8'd199};
      b_wr_data = {24'h0, 8'h99};
      b_wr_en   = 4'b0001;
      tick();
      b_wr_en = '0;
      chk("b_err_last", {31'b0, b_err}, 32'd0);
      chk("b_rd_old199", b_rd_data[31:24], 8'h00);
      tick();
      chk("b_rd_new199", b_rd_data[31:24], 8'h99);

      // read-before-write on the registered path
      b_wr_addr = {8'd0, 8'd0, 8'd0, 8'd7};
      b_wr_data = {24'h0, 8'h40};
      b_wr_en   = 4'b0001;
      tick();
      b_wr_data = {24'h0, 8'h41};
      b_rd_addr = {8'd0, 8'd0, 8'd0, 8'd7};
      tick();
      b_wr_en = '0;
      chk("b_rbw_old", b_rd_data[7:0], 8'h40);
      tick();
      chk("b_rbw_new", b_rd_data[7:0], 8'h41);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
